// File: rtl/mux_selector_pipe.sv
// rtl/mux_selector_pipe.sv - multi-lane flip/patch word selector with registered output and saturating stats
module mux_selector_pipe #(
  parameter int N = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16,
  parameter logic [N-1:0] PATCH_RESET = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*N-1:0]   in_data,
  input  logic [LANES-1:0]     in_flip,
  input  logic [LANES-1:0]     in_patch,
  input  logic                 patch_load,
  input  logic [N-1:0]         patch_value,
  input  logic                 cnt_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   out_data,
  output logic [2*LANES-1:0]   out_sel,
  output logic [CNT_W-1:0]     flip_count,
  output logic [CNT_W-1:0]     patch_count,
  output logic                 conflict
);

  localparam int SUM_W = CNT_W + $clog2(LANES) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [N-1:0]         patch_reg;
  logic                 accept;
  logic [LANES*N-1:0]   sel_data;
  logic [2*LANES-1:0]   sel_code;
  logic [SUM_W-1:0]     flip_pop;
  logic [SUM_W-1:0]     patch_pop;
  logic [SUM_W-1:0]     flip_sum;
  logic [SUM_W-1:0]     patch_sum;
  logic                 any_conflict;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Patch beats flip: a lane with both bits set outputs the patch word and is not counted as flipped.
  always_comb begin
    sel_data     = '0;
    sel_code     = '0;
    flip_pop     = '0;
    patch_pop    = '0;
    any_conflict = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (in_patch[k]) begin
        sel_data[k*N +: N] = patch_reg;
        sel_code[2*k +: 2] = 2'b10;
      end else if (in_flip[k]) begin
        sel_data[k*N +: N] = ~in_data[k*N +: N];
        sel_code[2*k +: 2] = 2'b01;
      end else begin
        sel_data[k*N +: N] = in_data[k*N +: N];
        sel_code[2*k +: 2] = 2'b00;
      end
      flip_pop     = flip_pop + {{(SUM_W-1){1'b0}}, (in_flip[k] & ~in_patch[k])};
      patch_pop    = patch_pop + {{(SUM_W-1){1'b0}}, in_patch[k]};
      any_conflict = any_conflict | (in_flip[k] & in_patch[k]);
    end
    flip_sum  = {{(SUM_W-CNT_W){1'b0}}, flip_count} + flip_pop;
    patch_sum = {{(SUM_W-CNT_W){1'b0}}, patch_count} + patch_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= sel_code;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      patch_reg <= PATCH_RESET;
    end else if (patch_load) begin
      patch_reg <= patch_value;
    end
  end

  // Clear wins over same-cycle events so the host sees a clean zero after clearing.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clear) begin
      flip_count  <= '0;
      patch_count <= '0;
      conflict    <= 1'b0;
    end else if (accept) begin
      flip_count  <= (flip_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : flip_sum[CNT_W-1:0];
      patch_count <= (patch_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : patch_sum[CNT_W-1:0];
      if (any_conflict) begin
        conflict <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_selector_pipe.sv
// tb/tb_mux_selector_pipe.sv - directed self-checking bench for mux_selector_pipe
module tb_mux_selector_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_flip;
  logic [3:0]  in_patch;
  logic        patch_load;
  logic [15:0] patch_value;
  logic        cnt_clear;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_sel;
  logic [7:0]  flip_count;
  logic [7:0]  patch_count;
  logic        conflict;

  int checks = 0;
  int errors = 0;

  mux_selector_pipe #(.N(16), .LANES(4), .CNT_W(8), .PATCH_RESET(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_flip(in_flip), .in_patch(in_patch),
    .patch_load(patch_load), .patch_value(patch_value), .cnt_clear(cnt_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .flip_count(flip_count), .patch_count(patch_count),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] f, input logic [3:0] p);
    in_valid = 1'b1;
    in_data  = d;
    in_flip  = f;
    in_patch = p;
  endtask

  task automatic idle_in;
    in_valid = 1'b0;
    in_flip  = '0;
    in_patch = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    patch_load = 1'b0;
    patch_value = '0;
    cnt_clear = 1'b0;
    idle_in();
    in_data = '0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom);
      in_data = {$urandom, $urandom};
      in_flip = 4'($urandom);
      in_patch = 4'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_sel", {56'd0, out_sel}, 64'd0);
    check("rst_flip_count", {56'd0, flip_count}, 64'd0);
    check("rst_patch_count", {56'd0, patch_count}, 64'd0);
    check("rst_conflict", {63'd0, conflict}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    rst_n = 1'b1;
    idle_in();
    out_ready = 1'b1;
    patch_load = 1'b1;
    patch_value = 16'hDEAD;
    tick();
    patch_load = 1'b0;

    // Selection mix
    beat({16'h0F0F, 16'hAAAA, 16'h00FF, 16'h1234}, 4'b0110, 4'b1000);
    tick();
    idle_in();
    check("mix_valid", {63'd0, out_valid}, 64'd1);
    check("mix_data", out_data, {16'hDEAD, 16'h5555, 16'hFF00, 16'h1234});
    check("mix_sel", {56'd0, out_sel}, {56'd0, 8'b10_01_01_00});
    check("mix_flip_count", {56'd0, flip_count}, 64'd2);
    check("mix_patch_count", {56'd0, patch_count}, 64'd1);
    check("mix_conflict", {63'd0, conflict}, 64'd0);
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // Conflict on lane 2
    patch_load = 1'b1;
    patch_value = 16'hBEEF;
    tick();
    patch_load = 1'b0;
    beat({16'h0000, 16'h1111, 16'h2222, 16'h3333}, 4'b0101, 4'b0100);
    tick();
    idle_in();
    check("cf_data", out_data, {16'h0000, 16'hBEEF, 16'h2222, 16'hCCCC});
    check("cf_sel", {56'd0, out_sel}, {56'd0, 8'b00_10_00_01});
    check("cf_conflict", {63'd0, conflict}, 64'd1);
    check("cf_flip_count", {56'd0, flip_count}, 64'd3);
    check("cf_patch_count", {56'd0, patch_count}, 64'd2);
    tick();
    tick();
    check("cf_sticky", {63'd0, conflict}, 64'd1);

    // Backpressure: A accepted, B and C wait
    out_ready = 1'b0;
    beat(64'h1000_2000_3000_4000, 4'b0001, 4'b0000);
    tick();
    beat(64'h5000_6000_7000_8000, 4'b0001, 4'b0000);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_data", out_data, 64'h1000_2000_3000_BFFF);
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    check("bp_one_beat_counted", {56'd0, flip_count}, 64'd4);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {63'd0, in_ready}, 64'd1);
    tick();
    check("bp_beat_b", out_data, 64'h5000_6000_7000_7FFF);
    beat(64'h9000_A000_B000_C000, 4'b0001, 4'b0000);
    tick();
    check("bp_beat_c", out_data, 64'h9000_A000_B000_3FFF);
    idle_in();
    tick();
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    check("bp_flip_count", {56'd0, flip_count}, 64'd6);

    // Patch load in the same cycle as an accepted patch beat
    patch_load = 1'b1;
    patch_value = 16'hDEAD;
    tick();
    patch_value = 16'h1111;
    beat(64'd0, 4'b0000, 4'b0001);
    tick();
    patch_load = 1'b0;
    check("race_old_patch", {48'd0, out_data[15:0]}, 64'hDEAD);
    beat(64'd0, 4'b0000, 4'b0001);
    tick();
    idle_in();
    check("race_new_patch", {48'd0, out_data[15:0]}, 64'h1111);
    check("race_patch_count", {56'd0, patch_count}, 64'd4);

    // Saturation: flip_count starts at 6, +4 per beat
    for (int i = 0; i < 70; i++) begin
      beat(64'd0, 4'b1111, 4'b0000);
      tick();
      if (i == 61) check("sat_254", {56'd0, flip_count}, 64'd254);
    end
    idle_in();
    check("sat_255", {56'd0, flip_count}, 64'd255);
    check("sat_last_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Clear beats same-cycle events, including a conflict
    cnt_clear = 1'b1;
    beat(64'd0, 4'b1111, 4'b1111);
    tick();
    cnt_clear = 1'b0;
    idle_in();
    check("clr_flip_count", {56'd0, flip_count}, 64'd0);
    check("clr_patch_count", {56'd0, patch_count}, 64'd0);
    check("clr_conflict", {63'd0, conflict}, 64'd0);
    check("clr_datapath", out_data, 64'h1111_1111_1111_1111);
    check("clr_sel", {56'd0, out_sel}, {56'd0, 8'hAA});

    // Reset while a beat is held
    out_ready = 1'b0;
    beat(64'h1234_5678_9ABC_DEF0, 4'b0000, 4'b0000);
    tick();
    idle_in();
    check("mid_held", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data", out_data, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_selector_pipe.md
Name: mux_selector_pipe

Overview:
- Multi-lane, pipelined successor of the single-word flip/patch selector used in the fault-mitigation datapath of the NN accelerator.
- Takes LANES words of N bits per beat. For each lane it picks one of three values:
  - the original word,
  - the internally bit-flipped (inverted) word,
  - a programmable patch word.
- Output is registered behind a valid/ready handshake.
- Keeps saturating statistics of flip and patch events for the fault-analysis host.

Parameters:
- N, 16: word width in bits.
- LANES, 4: words per beat.
- CNT_W, 16: width of each statistics counter.
- PATCH_RESET, 0: reset value of the patch register (N bits).

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- rst_n, input, 1: synchronous active-low reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block accepts a beat this cycle.
- in_data, input, LANES*N: lane k occupies bits [k*N +: N].
- in_flip, input, LANES: per-lane flip bit f.
- in_patch, input, LANES: per-lane patch bit p.
- patch_load, input, 1: load patch_value into the patch register.
- patch_value, input, N: new patch word.
- cnt_clear, input, 1: clear all statistics.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, LANES*N: selected words, same lane packing as in_data.
- out_sel, output, 2*LANES: per-lane selection code, lane k at bits [2k+:2]. 00 = original, 01 = flipped, 10 = patched; 11 is never produced.
- flip_count, output, CNT_W: lanes output as flipped since the last clear.
- patch_count, output, CNT_W: lanes output as patched since the last clear.
- conflict, output, 1: sticky flag; set when any accepted lane had p=1 and f=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Patch register = PATCH_RESET.
  - flip_count=0, patch_count=0, conflict=0.
  - in_ready follows its combinational equation, so it is 1 during and after reset.
  - Reset mid-transfer discards the held beat; no partial beat survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the accepted beat appears on out_data/out_sel with out_valid=1 on the next edge.
  - A held beat stays stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new beat is accepted in the same cycle.
  - Full throughput of 1 beat/cycle when out_ready is held at 1.
- Per-lane selection, priority identical to the single-word block:
  - p=1: patch register value, code 10.
  - else f=1: ~lane word (bitwise inversion), code 01.
  - else: lane word unchanged, code 00.
  - p=1 and f=1 together: patch wins, and conflict is set on acceptance.
- Patch register:
  - patch_load=1 writes patch_value at the clock edge.
  - A beat accepted in the same cycle as the load uses the OLD value. The new value applies from the next accepted beat.
- Statistics, updated only on accepted beats:
  - flip_count += popcount(in_flip & ~in_patch).
  - patch_count += popcount(in_patch).
  - Arithmetic is in CNT_W+log2(LANES)+1 bits; the result saturates at 2^CNT_W-1 and never wraps.
- cnt_clear=1:
  - Zeroes both counters and conflict.
  - Has priority over any increment or conflict set in the same cycle; that cycle's events are dropped.
  - Does not affect the datapath or the handshake.
- Lanes are independent; there is no cross-lane interaction except the shared patch register and counters.
- No combinational path from in_* to out_*. The only combinational path is out_ready -> in_ready.

Test Plan (N=16, LANES=4, CNT_W=8):
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles with random inputs driven.
  - Required response: out_valid=0, out_data=0, counters=0, conflict=0, in_ready=1.
- Selection mix:
  - Stimulus: out_ready=1; patch loaded with 16'hDEAD; beat with lanes {16'h1234, 16'h00FF, 16'hAAAA, 16'h0F0F}, in_flip=4'b0110, in_patch=4'b1000.
  - Required response: next cycle lanes 0..3 = {16'h1234, 16'hFF00, 16'h5555, 16'hDEAD} and out_sel=8'b10_01_01_00.
  - Counters: flip_count=2, patch_count=1, conflict=0.
- Conflict:
  - Stimulus: lane 2 with p=1 and f=1, patch register=16'hBEEF.
  - Required response: lane 2 outputs 16'hBEEF with code 10; conflict=1 and stays 1 until cnt_clear; flip_count not incremented for lane 2.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while in_valid=1 with 3 distinct beats queued.
  - Required response: first beat held stable, in_ready=0 after one beat, counters count only 1 beat. Releasing out_ready delivers the beats in order with no loss or duplication.
- Patch load race:
  - Stimulus: patch_load=1 with 16'h1111 in the same cycle a p=1 beat is accepted (old patch 16'hDEAD), then another p=1 beat.
  - Required response: outputs 16'hDEAD, then 16'h1111.
- Saturation and clear:
  - Stimulus: 70 beats with all-flip lanes.
  - Required response: flip_count saturates at 255 with no wrap.
  - Stimulus: cnt_clear asserted together with an accepted all-patch beat.
  - Required response: patch_count=0 and flip_count=0 on the next cycle.
